seg7_decoder: RTL and testbench
===============================

# seg7_decoder

Registered hexadecimal-to-seven-segment decoder. Converts a 4-bit binary nibble into the seven segment-drive lines of a single display digit, covering all sixteen values 0–F. Drive polarity is selectable for common-cathode or common-anode displays. It sits between the datapath nibble source and the display pins, with one register stage on the output.

## Interface
- seg_type, default 0: output polarity.
  - 0 = active-high segments (common cathode).
  - 1 = active-low segments (common anode).
  - Any other value is treated as 1.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset; one clock, reset asynchronous and active-low.
- d_in  input  4  binary nibble to display, 0x0–0xF.
- d_out  output  7  segment drive: bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g.

## Operation
- d_out is a register loaded every clock from decode(d_in); there is no enable.
- Active-high pattern (seg_type=0), shown as d_out[6:0] in hex:
  - 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07
  - 8→7F, 9→6F, A→77, b→7C, C→39, d→5E, E→79, F→71
- Letter forms: A upper, b lower, C upper, d lower, E upper, F upper.
- seg_type=1: d_out is the bitwise inverse of the active-high pattern (e.g. 0→40, 8→00).
- Polarity inversion is applied once, after decode. It is elaboration-time only, so there is no runtime polarity change.
- The decode is full-case over all 16 codes; there is no default or blank code in normal operation.
- X/Z on d_in is not a supported input; no behaviour is specified for it.
- Reset blanks the digit: all segments off, i.e. 7'b0000000 for seg_type=0 and 7'b1111111 for seg_type=1.

## Timing
- Latency: d_out reflects d_in sampled at a rising edge, valid after that edge (1 cycle).
- d_in must be stable for setup/hold around the edge; there is no combinational path from d_in to d_out.
- rst_n low forces d_out to the blank value immediately, without waiting for clk.
- While rst_n is low, d_out holds blank regardless of d_in or clk.
- Reset release is synchronous to the design: the first rising edge with rst_n high loads decode(d_in).
- The release edge must meet recovery/removal timing to the clock.
- Reset asserted mid-stream: the output is blanked at once, and the previously displayed digit is not retained.
- Back-to-back changes of d_in on consecutive cycles each appear on d_out one cycle later. No value is skipped or merged.

## Test plan
- Reset:
  - Assert rst_n=0 with d_in=8, seg_type=0, no clock edge → d_out=00 immediately.
  - With seg_type=1, the same stimulus → d_out=7F.
- Full sweep, seg_type=1:
  - Apply d_in 0..F, one value per clock.
  - → one cycle later d_out = ~pattern: 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E.
- Full sweep, seg_type=0: d_in 0..F → d_out 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F, 77, 7C, 39, 5E, 79, 71.
- Latency check:
  - Change d_in 3→C between edges → d_out stays 4F (seg_type=0) until the next rising edge, then 39.
  - No change is allowed before that edge.
- Mid-operation reset:
  - Display 5 (6D) and pulse rst_n low for half a cycle → d_out=00 during the pulse.
  - With d_in=5, the first edge after release → 6D.
- Consecutive alternation:
  - Apply d_in toggling 0↔F every cycle for 8 cycles → d_out alternates 3F/71 with exactly one cycle of lag.

Source files
------------

// File: rtl/seg7_decoder_if.sv
// Nibble-to-display link between a datapath nibble source and a 7-segment decoder.
//   d_in  : 4-bit binary nibble to display (0x0-0xF)
//   d_out : 7-bit segment drive, bit0=a ... bit6=g
// Modports: master drives d_in and observes d_out; slave (the decoder) does the reverse.
interface seg7_decoder_if;
    localparam int unsigned NIB_W = 4;
    localparam int unsigned SEG_W = 7;

    logic [NIB_W-1:0] d_in;
    logic [SEG_W-1:0] d_out;

    modport master (output d_in, input d_out);
    modport slave  (input d_in, output d_out);
endinterface

// File: rtl/seg7_decoder.sv
// Registered hex-to-seven-segment decoder for a single display digit.
//   seg_type : 0 = active-high segments (common cathode); any other value = active-low (common anode)
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset, blanks the digit
//   bus      : slave side of seg7_decoder_if (d_in nibble in, registered d_out segments out)
module seg7_decoder #(
    parameter int unsigned seg_type = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seg7_decoder_if.slave        bus
);
    localparam int unsigned SEG_W = 7;
    localparam bit          INVERT = (seg_type != 0);
    // All segments off in the chosen polarity.
    localparam logic [SEG_W-1:0] BLANK = INVERT ? SEG_W'(7'h7F) : SEG_W'(7'h00);

    logic [SEG_W-1:0] pattern_c;
    logic [SEG_W-1:0] d_out_d;
    logic [SEG_W-1:0] d_out_q;

    // Active-high glyphs; letters shown as A b C d E F.
    always_comb begin
        pattern_c = SEG_W'(7'h00);
        case (bus.d_in)
            4'h0: pattern_c = SEG_W'(7'h3F);
            4'h1: pattern_c = SEG_W'(7'h06);
            4'h2: pattern_c = SEG_W'(7'h5B);
            4'h3: pattern_c = SEG_W'(7'h4F);
            4'h4: pattern_c = SEG_W'(7'h66);
            4'h5: pattern_c = SEG_W'(7'h6D);
            4'h6: pattern_c = SEG_W'(7'h7D);
            4'h7: pattern_c = SEG_W'(7'h07);
            4'h8: pattern_c = SEG_W'(7'h7F);
            4'h9: pattern_c = SEG_W'(7'h6F);
            4'hA: pattern_c = SEG_W'(7'h77);
            4'hB: pattern_c = SEG_W'(7'h7C);
            4'hC: pattern_c = SEG_W'(7'h39);
            4'hD: pattern_c = SEG_W'(7'h5E);
            4'hE: pattern_c = SEG_W'(7'h79);
            4'hF: pattern_c = SEG_W'(7'h71);
            default: pattern_c = SEG_W'(7'h00);
        endcase
    end

    // Polarity applied once, after decode.
    always_comb begin
        d_out_d = pattern_c;
        if (INVERT) begin
            d_out_d = ~pattern_c;
        end
    end

    // Output register; reset blanks immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_out_q <= BLANK;
        end else begin
            d_out_q <= d_out_d;
        end
    end

    assign bus.d_out = d_out_q;
endmodule

// File: tb/tb_seg7_decoder.sv
// Directed bench for seg7_decoder: one common-cathode and one common-anode instance
// driven with identical nibbles and checked against hand-computed segment codes.
module tb_seg7_decoder;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [6:0] pat_hi [16];
    logic [6:0] pat_lo [16];

    seg7_decoder_if if_cc ();
    seg7_decoder_if if_ca ();

    seg7_decoder #(.seg_type(0)) u_cc (.clk(clk), .rst_n(rst_n), .bus(if_cc.slave));
    seg7_decoder #(.seg_type(1)) u_ca (.clk(clk), .rst_n(rst_n), .bus(if_ca.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v);
        if_cc.d_in = v;
        if_ca.d_in = v;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        pat_hi = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        pat_lo = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        rst_n = 1'b1;
        drive(4'h8);

        // Asynchronous reset before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_cc", if_cc.d_out, 7'h00);
        check("rst_async_ca", if_ca.d_out, 7'h7F);

        // Reset holds blank across edges and input changes.
        @(posedge clk); drive(4'h0);
        @(posedge clk); #1;
        check("rst_hold_cc", if_cc.d_out, 7'h00);
        check("rst_hold_ca", if_ca.d_out, 7'h7F);
        @(negedge clk) rst_n = 1'b1;

        // Full sweep 0..F, one value per clock.
        for (int i = 0; i < 16; i++) begin
            drive(4'(i));
            @(posedge clk); #1;
            check($sformatf("sweep_cc_%0h", i), if_cc.d_out, pat_hi[i]);
            check($sformatf("sweep_ca_%0h", i), if_ca.d_out, pat_lo[i]);
            @(negedge clk);
        end

        // Latency: mid-cycle change must not reach the output before the next edge.
        drive(4'h3);
        @(posedge clk); #1;
        check("lat_first_cc", if_cc.d_out, 7'h4F);
        #2 drive(4'hC);
        #1 check("lat_hold_cc", if_cc.d_out, 7'h4F);
        check("lat_hold_ca", if_ca.d_out, 7'h30);
        @(negedge clk); #2;
        check("lat_hold2_cc", if_cc.d_out, 7'h4F);
        @(posedge clk); #1;
        check("lat_next_cc", if_cc.d_out, 7'h39);
        check("lat_next_ca", if_ca.d_out, 7'h46);

        // Mid-operation reset pulse while displaying 5.
        @(negedge clk) drive(4'h5);
        @(posedge clk); #1;
        check("mid_pre_cc", if_cc.d_out, 7'h6D);
        rst_n = 1'b0;
        #1;
        check("mid_rst_cc", if_cc.d_out, 7'h00);
        check("mid_rst_ca", if_ca.d_out, 7'h7F);
        #4 rst_n = 1'b1;
        #1;
        check("mid_rel_cc", if_cc.d_out, 7'h00);
        @(posedge clk); #1;
        check("mid_post_cc", if_cc.d_out, 7'h6D);
        check("mid_post_ca", if_ca.d_out, 7'h12);

        // 0/F alternation: each value appears exactly one edge later.
        for (int i = 0; i < 8; i++) begin
            logic [3:0] v;
            logic [6:0] prev_hi;
            v = (i % 2 == 0) ? 4'h0 : 4'hF;
            prev_hi = (i == 0) ? 7'h6D : ((i % 2 == 0) ? 7'h71 : 7'h3F);
            @(negedge clk) drive(v);
            #1 check($sformatf("alt_lag_cc_%0d", i), if_cc.d_out, prev_hi);
            @(posedge clk); #1;
            check($sformatf("alt_cc_%0d", i), if_cc.d_out, (i % 2 == 0) ? 7'h3F : 7'h71);
            check($sformatf("alt_ca_%0d", i), if_ca.d_out, (i % 2 == 0) ? 7'h40 : 7'h0E);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
